// File: rtl/spb_arbiter.sv
// spb_arbiter: two-master, one-slave SPB arbiter. It uses round-robin arbitration
// and grants one transaction at a time. Optional watchdog macro: SPB_ARB_TIMEOUT_EN.
//
// Parameters:
//   TIMEOUT  cycles a granted transaction may wait for S_SPB_READY (watchdog)
//   TO_W     watchdog counter width, 2**TO_W > TIMEOUT
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   M0_SPB_*, M1_SPB_*           master sides: VALID/ADDR/WSTB/WDATA in,
//                                READY/RDATA/EXCPT out
//   S_SPB_*                      slave side: VALID/ADDR/WSTB/WDATA out,
//                                READY/RDATA/EXCPT in
// With SPB_ARB_TIMEOUT_EN defined, a transaction that goes unanswered is
// terminated through a one-cycle ABORT state. ABORT returns READY=1 and
// EXCPT=1 to the granted master.

module spb_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        M0_SPB_VALID,
    input  logic [31:0] M0_SPB_ADDR,
    input  logic [3:0]  M0_SPB_WSTB,
    input  logic [31:0] M0_SPB_WDATA,
    output logic        M0_SPB_READY,
    output logic [31:0] M0_SPB_RDATA,
    output logic        M0_SPB_EXCPT,

    input  logic        M1_SPB_VALID,
    input  logic [31:0] M1_SPB_ADDR,
    input  logic [3:0]  M1_SPB_WSTB,
    input  logic [31:0] M1_SPB_WDATA,
    output logic        M1_SPB_READY,
    output logic [31:0] M1_SPB_RDATA,
    output logic        M1_SPB_EXCPT,

    output logic        S_SPB_VALID,
    output logic [31:0] S_SPB_ADDR,
    output logic [3:0]  S_SPB_WSTB,
    output logic [31:0] S_SPB_WDATA,
    input  logic        S_SPB_READY,
    input  logic [31:0] S_SPB_RDATA,
    input  logic        S_SPB_EXCPT
);

`ifdef SPB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1
    } state_t;
`endif

    // The watchdog counter must be able to reach TIMEOUT.
    if (TIMEOUT >= (1 << TO_W)) begin : g_bad_cfg
        $error("spb_arbiter: TO_W too small for TIMEOUT");
    end

    state_t state;
    logic   grant;
    logic   last;

    logic   busy;
    logic   abort;
    logic   req_valid;
    logic   done;
    logic   pick;

`ifdef SPB_ARB_TIMEOUT_EN
    logic [TO_W-1:0] count;
    logic            expired;

    assign expired = (count == TO_W'(TIMEOUT));
    assign abort   = (state == ABORT);
`else
    assign abort   = 1'b0;
`endif

    assign busy      = (state == BUSY);
    assign req_valid = grant ? M1_SPB_VALID : M0_SPB_VALID;

    // A response is forwarded only while the granted request is still up.
    // A stray READY in IDLE or ABORT never reaches a master.
    assign done = busy & req_valid & S_SPB_READY;

    // On a tie, grant the master that was not served last.
    assign pick = (M0_SPB_VALID & M1_SPB_VALID) ? ~last : M1_SPB_VALID;

    // Slave side: forward the granted master only while BUSY.
    assign S_SPB_VALID = busy & req_valid;
    assign S_SPB_ADDR  = !busy ? 32'd0 :
                         grant ? M1_SPB_ADDR : M0_SPB_ADDR;
    assign S_SPB_WSTB  = !busy ? 4'd0 :
                         grant ? M1_SPB_WSTB : M0_SPB_WSTB;
    assign S_SPB_WDATA = !busy ? 32'd0 :
                         grant ? M1_SPB_WDATA : M0_SPB_WDATA;

    // Master side: only the granted master sees a response.
    assign M0_SPB_READY = ~grant & (done | abort);
    assign M0_SPB_RDATA = (~grant & done) ? S_SPB_RDATA : 32'd0;
    assign M0_SPB_EXCPT = ~grant & ((done & S_SPB_EXCPT) | abort);

    assign M1_SPB_READY = grant & (done | abort);
    assign M1_SPB_RDATA = (grant & done) ? S_SPB_RDATA : 32'd0;
    assign M1_SPB_EXCPT = grant & ((done & S_SPB_EXCPT) | abort);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
`ifdef SPB_ARB_TIMEOUT_EN
            count <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (M0_SPB_VALID | M1_SPB_VALID) begin
                        state <= BUSY;
                        grant <= pick;
                        last  <= pick;
`ifdef SPB_ARB_TIMEOUT_EN
                        count <= '0;
`endif
                    end
                end
                BUSY: begin
                    // A real response wins over a watchdog expiry
                    // in the same cycle.
                    if (!req_valid || S_SPB_READY) begin
                        state <= IDLE;
                    end
`ifdef SPB_ARB_TIMEOUT_EN
                    else if (expired) begin
                        state <= ABORT;
                    end else begin
                        count <= count + 1'b1;
                    end
`endif
                end
`ifdef SPB_ARB_TIMEOUT_EN
                ABORT: begin
                    state <= IDLE;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spb_arbiter.sv
// tb_spb_arbiter: randomized self-checking bench for spb_arbiter.
// It checks directed scenarios and random rounds against a transaction-level model.

module tb_spb_arbiter;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;

    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr;
    logic [3:0]  m0_wstb, m1_wstb;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_excpt, m1_excpt;

    logic        s_valid;
    logic [31:0] s_addr;
    logic [3:0]  s_wstb;
    logic [31:0] s_wdata;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        s_excpt;

    spb_arbiter #(
        .TIMEOUT(TIMEOUT),
        .TO_W   (4)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .M0_SPB_VALID(m0_valid),
        .M0_SPB_ADDR (m0_addr),
        .M0_SPB_WSTB (m0_wstb),
        .M0_SPB_WDATA(m0_wdata),
        .M0_SPB_READY(m0_ready),
        .M0_SPB_RDATA(m0_rdata),
        .M0_SPB_EXCPT(m0_excpt),
        .M1_SPB_VALID(m1_valid),
        .M1_SPB_ADDR (m1_addr),
        .M1_SPB_WSTB (m1_wstb),
        .M1_SPB_WDATA(m1_wdata),
        .M1_SPB_READY(m1_ready),
        .M1_SPB_RDATA(m1_rdata),
        .M1_SPB_EXCPT(m1_excpt),
        .S_SPB_VALID (s_valid),
        .S_SPB_ADDR  (s_addr),
        .S_SPB_WSTB  (s_wstb),
        .S_SPB_WDATA (s_wdata),
        .S_SPB_READY (s_ready),
        .S_SPB_RDATA (s_rdata),
        .S_SPB_EXCPT (s_excpt)
    );

    always #5 clk = ~clk;

    // Transaction-level model: pending request per master and the
    // master served most recently.
    logic        pend[2];
    logic [31:0] addr[2];
    logic [3:0]  wstb[2];
    logic [31:0] wdata[2];
    int          mlast;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic get_ready(input int i);
        return (i == 0) ? m0_ready : m1_ready;
    endfunction

    function automatic logic [31:0] get_rdata(input int i);
        return (i == 0) ? m0_rdata : m1_rdata;
    endfunction

    function automatic logic get_excpt(input int i);
        return (i == 0) ? m0_excpt : m1_excpt;
    endfunction

    task automatic drive();
        m0_valid = pend[0];
        m0_addr  = addr[0];
        m0_wstb  = wstb[0];
        m0_wdata = wdata[0];
        m1_valid = pend[1];
        m1_addr  = addr[1];
        m1_wstb  = wstb[1];
        m1_wdata = wdata[1];
    endtask

    task automatic new_req(input int i);
        pend[i]  = 1'b1;
        addr[i]  = $urandom;
        wstb[i]  = 4'($urandom);
        wdata[i] = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"},
              32'({s_valid, s_wstb, m0_ready, m0_excpt,
                   m1_ready, m1_excpt}), 32'd0);
        check({tag, "_saddr"}, s_addr, 32'd0);
        check({tag, "_swdata"}, s_wdata, 32'd0);
        check({tag, "_m0rdata"}, m0_rdata, 32'd0);
        check({tag, "_m1rdata"}, m1_rdata, 32'd0);
    endtask

    task automatic check_fwd(input int w);
        check("s_valid", 32'(s_valid), 32'd1);
        check("s_addr", s_addr, addr[w]);
        check("s_wstb", 32'(s_wstb), 32'(wstb[w]));
        check("s_wdata", s_wdata, wdata[w]);
        check("other_ready", 32'(get_ready(1 - w)), 32'd0);
        check("other_rdata", get_rdata(1 - w), 32'd0);
        check("other_excpt", 32'(get_excpt(1 - w)), 32'd0);
    endtask

    // One transaction from IDLE through completion. On entry we are just
    // past a rising edge and the arbiter is idle.
    task automatic do_round(input int lat, input logic [31:0] rd,
                            input logic ex, input logic stray,
                            output int w);
        drive();
        s_ready = stray;
        s_rdata = $urandom;
        s_excpt = stray;
        @(negedge clk);
        check("idle_s_valid", 32'(s_valid), 32'd0);
        check("idle_m0_ready", 32'(m0_ready), 32'd0);
        check("idle_m1_ready", 32'(m1_ready), 32'd0);
        if (pend[0] && pend[1]) w = 1 - mlast;
        else w = pend[1] ? 1 : 0;
        mlast = w;
        step();
        s_ready = 1'b0;
        s_excpt = 1'b0;
        for (int i = 0; i < lat; i++) begin
            s_rdata = $urandom;
            @(negedge clk);
            check_fwd(w);
            check("stall_ready", 32'(get_ready(w)), 32'd0);
            step();
        end
        s_ready = 1'b1;
        s_rdata = rd;
        s_excpt = ex;
        @(negedge clk);
        check_fwd(w);
        check("resp_ready", 32'(get_ready(w)), 32'd1);
        check("resp_rdata", get_rdata(w), rd);
        check("resp_excpt", 32'(get_excpt(w)), 32'(ex));
        step();
        s_ready = 1'b0;
        s_excpt = 1'b0;
        pend[w] = 1'b0;
    endtask

    initial begin
        int w;

        s_ready = 1'b0;
        s_rdata = 32'd0;
        s_excpt = 1'b0;
        new_req(0);
        new_req(1);
        drive();
        rst   = 1'b1;
        mlast = 1;

        // Reset: outputs stay 0 even with requests and a stray response.
        step();
        s_ready = 1'b1;
        s_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        check_zero("reset");
        step();
        rst     = 1'b0;
        s_ready = 1'b0;

        // Simultaneous requests after reset, then both keep requesting.
        for (int i = 0; i < 6; i++) begin
            do_round($urandom_range(0, 3), $urandom, 1'b0, 1'b0, w);
            check("rr_order", 32'(w), 32'(i % 2));
            new_req(w);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;

        // M0 read with three stall cycles.
        pend[0]  = 1'b1;
        addr[0]  = 32'h0000_0010;
        wstb[0]  = 4'b0000;
        wdata[0] = 32'd0;
        do_round(3, 32'hDEAD_BEEF, 1'b0, 1'b0, w);
        check("m0_read_winner", 32'(w), 32'd0);

        // M1 partial write.
        pend[1]  = 1'b1;
        addr[1]  = 32'h0000_0100;
        wstb[1]  = 4'b0011;
        wdata[1] = 32'h1234_5678;
        do_round(1, 32'd0, 1'b0, 1'b0, w);
        check("m1_write_winner", 32'(w), 32'd1);

        // Master withdraws VALID while BUSY: no response returned.
        new_req(0);
        drive();
        step();
        mlast = 0;
        @(negedge clk);
        check("drop_s_valid_busy", 32'(s_valid), 32'd1);
        step();
        pend[0] = 1'b0;
        drive();
        s_ready = 1'b1;
        s_rdata = 32'h5555_AAAA;
        @(negedge clk);
        check("drop_s_valid", 32'(s_valid), 32'd0);
        check("drop_m0_ready", 32'(m0_ready), 32'd0);
        check("drop_m0_rdata", m0_rdata, 32'd0);
        step();
        s_ready = 1'b0;

        // Reset while BUSY with the slave stalled.
        new_req(1);
        drive();
        step();
        @(negedge clk);
        check("rst_busy_s_valid", 32'(s_valid), 32'd1);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check_zero("rst_busy");
        step();
        rst     = 1'b0;
        mlast   = 1;
        pend[1] = 1'b0;
        drive();
        s_ready = 1'b1;
        s_excpt = 1'b1;
        @(negedge clk);
        check("stray_m0_ready", 32'(m0_ready), 32'd0);
        check("stray_m1_ready", 32'(m1_ready), 32'd0);
        step();
        s_ready = 1'b0;
        s_excpt = 1'b0;

`ifdef SPB_ARB_TIMEOUT_EN
        // Unanswered request: abort in the tenth cycle after VALID.
        new_req(0);
        drive();
        for (int k = 1; k <= 10; k++) begin
            step();
            s_rdata = $urandom | 32'h1;
            @(negedge clk);
            if (k < 10) begin
                check("wd_wait_ready", 32'(m0_ready), 32'd0);
                check("wd_wait_s_valid", 32'(s_valid), 32'd1);
            end else begin
                check("wd_abort_ready", 32'(m0_ready), 32'd1);
                check("wd_abort_excpt", 32'(m0_excpt), 32'd1);
                check("wd_abort_rdata", m0_rdata, 32'd0);
                check("wd_abort_s_valid", 32'(s_valid), 32'd0);
                check("wd_abort_m1_ready", 32'(m1_ready), 32'd0);
            end
        end
        step();
        pend[0] = 1'b0;
        mlast   = 0;
        drive();
        @(negedge clk);
        check("wd_after_s_valid", 32'(s_valid), 32'd0);
        check("wd_after_ready", 32'(m0_ready), 32'd0);
        step();

        // Response in the same cycle as expiry wins.
        new_req(1);
        do_round(TIMEOUT, 32'hCAFE_F00D, 1'b0, 1'b0, w);
        check("wd_race_winner", 32'(w), 32'd1);
`else
        // No watchdog: a very slow slave still completes normally.
        new_req(0);
        do_round(1000, 32'h0BAD_CAFE, 1'b1, 1'b0, w);
        check("slow_winner", 32'(w), 32'd0);
`endif

        // Random traffic.
        for (int r = 0; r < 300; r++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
            if (!pend[0] && !pend[1]) new_req($urandom_range(0, 1));
            do_round($urandom_range(0, 4), $urandom,
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), w);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
